// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths here define the 8-bit datapath generation.
package reg_file_pkg;

   localparam int DEFAULT_DATA_W   = 8;
   localparam int DEFAULT_NUM_REGS = 8;
   localparam int DEFAULT_AW       = $clog2(DEFAULT_NUM_REGS);
   localparam int ZERO_ADDR        = 0;

   typedef logic [DEFAULT_AW-1:0]     addr_t;
   typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: one busy bit per register, a registered pending count and a sticky
// protocol-error flag. Strobes arrive already masked for the hard-wired zero register.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   output logic [NUM_REGS-1:0] busy,
   output logic [AW:0]         pending_cnt,
   output logic                sb_error
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [AW:0]         cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                same_reg;

   assign same_reg = issue_en && wr_en && (issue_addr == wr_addr);

   // A new producer wins over a retiring one, so issue is applied after writeback.
   // The count is the population of the next busy vector, so it cannot drift or wrap.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (issue_en) begin
         busy_d[issue_addr] = 1'b1;
      end

      cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d = cnt_d + (AW+1)'(busy_d[i]);
      end

      err_d = err_q;
      if (wr_en && !busy_q[wr_addr] && !same_reg) begin
         err_d = 1'b1;
      end
      if (issue_en && busy_q[issue_addr] && !same_reg) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy        = busy_q;
   assign pending_cnt = cnt_q;
   assign sb_error    = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with optional write-through bypass, optional hard-wired
// zero register, and a busy scoreboard for RAW hazard detection at decode.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [AW-1:0]     rd_addr1,
   input  logic [AW-1:0]     rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_addr,
   output logic [AW:0]       pending_cnt,
   output logic              sb_error
);

   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [DATA_W-1:0]   rf_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                wr_ok, issue_ok;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == AW'(ZERO_ADDR));
   endfunction

   // Traffic aimed at the zero register is dropped before it reaches storage or scoreboard.
   assign wr_ok    = wr_en && !is_zero(wr_addr);
   assign issue_ok = issue_en && !is_zero(issue_addr);

   reg_file_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_scoreboard (
      .clock       (clock),
      .reset       (reset),
      .issue_en    (issue_ok),
      .issue_addr  (issue_addr),
      .wr_en       (wr_ok),
      .wr_addr     (wr_addr),
      .busy        (busy),
      .pending_cnt (pending_cnt),
      .sb_error    (sb_error)
   );

   always_comb begin
      rf_d = rf_q;
      if (wr_ok) begin
         rf_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   // Bypass forwards writeback data and retires the busy flag in the same cycle,
   // unless a new producer to that register is being issued alongside.
   always_comb begin
      rd_data1 = rf_q[rd_addr1];
      rd_data2 = rf_q[rd_addr2];
      rd_busy1 = busy[rd_addr1];
      rd_busy2 = busy[rd_addr2];

      if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
         if (!(issue_ok && (issue_addr == rd_addr1))) begin
            rd_busy1 = 1'b0;
         end
      end
      if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr2)) begin
         rd_data2 = wr_data;
         if (!(issue_ok && (issue_addr == rd_addr2))) begin
            rd_busy2 = 1'b0;
         end
      end

      if (is_zero(rd_addr1)) begin
         rd_data1 = '0;
         rd_busy1 = 1'b0;
      end
      if (is_zero(rd_addr2)) begin
         rd_data2 = '0;
         rd_busy2 = 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a bypassing and a non-bypassing instance share stimulus,
// a behavioural register-file model queues expectations, and a negedge monitor checks them.
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] rd_addr1, rd_addr2, wr_addr, issue_addr;
   logic [7:0] wr_data;
   logic       wr_en, issue_en;

   logic [7:0] bp_data1, bp_data2, nb_data1, nb_data2;
   logic       bp_busy1, bp_busy2, nb_busy1, nb_busy2;
   logic [3:0] bp_cnt, nb_cnt;
   logic       bp_err, nb_err;

   typedef struct {
      logic [7:0] bp_d1, bp_d2, nb_d1, nb_d2;
      logic       bp_b1, bp_b2, nb_b1, nb_b2;
      logic [3:0] cnt;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;

   logic [7:0] m_rf [8];
   logic       m_busy [8];
   logic       m_err;

   always #5 clock = ~clock;

   reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .BYPASS(1), .ZERO_REG(1)) dut (
      .clock(clock), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(bp_data1), .rd_data2(bp_data2),
      .rd_busy1(bp_busy1), .rd_busy2(bp_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_addr(issue_addr),
      .pending_cnt(bp_cnt), .sb_error(bp_err)
   );

   reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clock(clock), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(nb_data1), .rd_data2(nb_data2),
      .rd_busy1(nb_busy1), .rd_busy2(nb_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_addr(issue_addr),
      .pending_cnt(nb_cnt), .sb_error(nb_err)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register 0 is hard-wired: reads 0, never busy, never written.
   function automatic logic [7:0] model_read(input logic [2:0] a, input logic fwd);
      if (a == 3'd0) return 8'h00;
      if (fwd && wr_en && wr_addr == a) return wr_data;
      return m_rf[a];
   endfunction

   function automatic logic model_busy(input logic [2:0] a, input logic fwd);
      if (a == 3'd0) return 1'b0;
      if (fwd && wr_en && wr_addr == a && !(issue_en && issue_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_rf[i]   = 8'h00;
         m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
   endtask

   task automatic apply_stimulus(input logic rst, input logic we, input logic [2:0] wa,
                                 input logic [7:0] wd, input logic ie, input logic [2:0] ia,
                                 input logic [2:0] ra1, input logic [2:0] ra2);
      exp_t e;
      int   n;
      logic iss_v, wr_v;
      @(posedge clock);
      #1;
      reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
      issue_en = ie; issue_addr = ia; rd_addr1 = ra1; rd_addr2 = ra2;

      n = 0;
      for (int i = 0; i < 8; i++) n += m_busy[i] ? 1 : 0;
      e.bp_d1 = model_read(ra1, 1'b1);
      e.bp_d2 = model_read(ra2, 1'b1);
      e.nb_d1 = model_read(ra1, 1'b0);
      e.nb_d2 = model_read(ra2, 1'b0);
      e.bp_b1 = model_busy(ra1, 1'b1);
      e.bp_b2 = model_busy(ra2, 1'b1);
      e.nb_b1 = model_busy(ra1, 1'b0);
      e.nb_b2 = model_busy(ra2, 1'b0);
      e.cnt   = 4'(n);
      e.err   = m_err;
      exp_q.push_back(e);

      if (rst) begin
         model_reset();
      end else begin
         iss_v = ie && ia != 3'd0;
         wr_v  = we && wa != 3'd0;
         if (wr_v && !m_busy[wa] && !(iss_v && ia == wa)) m_err = 1'b1;
         if (iss_v && m_busy[ia] && !(wr_v && wa == ia)) m_err = 1'b1;
         if (wr_v) begin
            m_rf[wa]   = wd;
            m_busy[wa] = 1'b0;
         end
         if (iss_v) m_busy[ia] = 1'b1;
      end
   endtask

   task automatic idle_read(input logic [2:0] ra1, input logic [2:0] ra2);
      apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, ra1, ra2);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("bp_rd_data1", 32'(bp_data1), 32'(e.bp_d1));
            check_output("bp_rd_data2", 32'(bp_data2), 32'(e.bp_d2));
            check_output("nb_rd_data1", 32'(nb_data1), 32'(e.nb_d1));
            check_output("nb_rd_data2", 32'(nb_data2), 32'(e.nb_d2));
            check_output("bp_rd_busy1", 32'(bp_busy1), 32'(e.bp_b1));
            check_output("bp_rd_busy2", 32'(bp_busy2), 32'(e.bp_b2));
            check_output("nb_rd_busy1", 32'(nb_busy1), 32'(e.nb_b1));
            check_output("nb_rd_busy2", 32'(nb_busy2), 32'(e.nb_b2));
            check_output("bp_pending_cnt", 32'(bp_cnt), 32'(e.cnt));
            check_output("nb_pending_cnt", 32'(nb_cnt), 32'(e.cnt));
            check_output("bp_sb_error", 32'(bp_err), 32'(e.err));
            check_output("nb_sb_error", 32'(nb_err), 32'(e.err));
         end
      end
   end

   initial begin : stimulus
      logic [2:0] a;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
      model_reset();
      @(posedge clock);

      // Post-reset: every register reads zero and idle.
      for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(7 - i));

      // Same-cycle forwarding versus stored-value read.
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd3, 3'd1);
      idle_read(3'd3, 3'd3);
      apply_stimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd0);

      // Zero register ignores write and issue.
      apply_stimulus(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
      idle_read(3'd0, 3'd0);

      // Two producers outstanding, one retires.
      apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd5, 3'd6);
      apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd5, 3'd6);
      apply_stimulus(1'b0, 1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 3'd5, 3'd6);
      idle_read(3'd5, 3'd6);

      // Issue and writeback to the same busy register in one cycle.
      apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd6);
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'h33, 1'b1, 3'd2, 3'd2, 3'd2);
      idle_read(3'd2, 3'd6);

      // Writeback to a non-busy register latches the error; mid-flight reset clears all.
      apply_stimulus(1'b0, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 3'd4, 3'd2);
      idle_read(3'd4, 3'd1);
      apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd2);
      apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 3'd2);
      apply_stimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd2);
      idle_read(3'd4, 3'd6);

      // Randomized traffic, writebacks steered toward busy registers most of the time.
      for (int n = 0; n < 400; n++) begin
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 8; k++) begin
               if (m_busy[3'(a + 3'(k))]) begin
                  a = 3'(a + 3'(k));
                  break;
               end
            end
         end
         apply_stimulus($urandom_range(0, 39) == 0,
                        1'($urandom_range(0, 1)), a, 8'($urandom),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        $urandom_range(0, 1) ? a : 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)));
      end

      idle_read(3'd0, 3'd0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      if (exp_q.size() > 0) begin
         mismatched++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
